tpg_frame_sequencer: RTL and testbench



---
 rtl/tpg_frame_sequencer_if.sv | 20 ++
 rtl/tpg_frame_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_tpg_frame_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpg_frame_sequencer_if.sv
// Host register bus for tpg_frame_sequencer.
//   cfg_wr_i    : write strobe, one cycle per write
//   cfg_rd_i    : read strobe; cfg_rdata_o is valid the following cycle
//   cfg_addr_i  : register address (0..7)
//   cfg_wdata_i : write data
//   cfg_rdata_o : registered read data
// Signal names are from the sequencer's point of view; the host side
// uses the master modport and the sequencer uses the slave modport.
interface tpg_frame_sequencer_if;
   logic        cfg_wr_i;
   logic        cfg_rd_i;
   logic [2:0]  cfg_addr_i;
   logic [15:0] cfg_wdata_i;
   logic [15:0] cfg_rdata_o;

   modport master (output cfg_wr_i, cfg_rd_i, cfg_addr_i, cfg_wdata_i,
                   input  cfg_rdata_o);
   modport slave  (input  cfg_wr_i, cfg_rd_i, cfg_addr_i, cfg_wdata_i,
                   output cfg_rdata_o);
endinterface

// File: rtl/tpg_frame_sequencer.sv
// Control/configuration front end for the FV/LV colour-bar pattern
// generator. The host programs shadow registers (width, height, line
// blanking, fps); the values reach the generator only at a frame boundary
// (FV falling edge) or while stopped. The generator is started/stopped via
// its reset, completed frames are counted and status is reported.
//
// Ports:
//   clk, reset_n      : single clock, synchronous active-low reset
//   cfg               : host register bus (tpg_frame_sequencer_if.slave)
//   fv_i              : frame valid from the generator
//   gen_reset_n_o     : generator reset, low keeps it idle
//   image_width_o, image_height_o, line_blanking_o, img_fps_o
//                     : active configuration driven to the generator
//   running_o         : sequencer is starting or running
//   cfg_pending_o     : commit requested but not yet applied
//   frame_done_o      : one-cycle pulse per counted FV fall
//
// Register map: 0 width, 1 height, 2 hblank, 3 fps (shadow, read back),
//   4 control (bit0 run, bit1 commit), 5 status (bit0 running, bit1 pending,
//   bit2 cfg_error, write 1 to bit2 to clear), 6 frame count, 7 reserved.
//
// Optional build macro TPG_SEQ_STOP_TIMEOUT_EN: when defined, a stop that
// sees no FV fall within STOP_TIMEOUT_CYCLES is forced to completion and
// flags cfg_error. When undefined, stopping waits for FV indefinitely.
module tpg_frame_sequencer #(
   parameter logic [15:0] DEFAULT_WIDTH       = 16'd1920,
   parameter logic [15:0] DEFAULT_HEIGHT      = 16'd1080,
   parameter logic [15:0] DEFAULT_HBLANK      = 16'd100,
   parameter logic [7:0]  DEFAULT_FPS         = 8'd30,
   parameter int unsigned STOP_TIMEOUT_CYCLES = 4_000_000
) (
   input  logic                        clk,
   input  logic                        reset_n,
   tpg_frame_sequencer_if.slave        cfg,
   input  logic                        fv_i,
   output logic                        gen_reset_n_o,
   output logic [15:0]                 image_width_o,
   output logic [15:0]                 image_height_o,
   output logic [15:0]                 line_blanking_o,
   output logic [7:0]                  img_fps_o,
   output logic                        running_o,
   output logic                        cfg_pending_o,
   output logic                        frame_done_o
);
   localparam logic [2:0] A_WIDTH  = 3'd0;
   localparam logic [2:0] A_HEIGHT = 3'd1;
   localparam logic [2:0] A_HBLANK = 3'd2;
   localparam logic [2:0] A_FPS    = 3'd3;
   localparam logic [2:0] A_CTRL   = 3'd4;
   localparam logic [2:0] A_STAT   = 3'd5;
   localparam logic [2:0] A_FCNT   = 3'd6;

   typedef enum logic [1:0] {
      ST_STOPPED  = 2'd0,
      ST_START    = 2'd1,
      ST_RUNNING  = 2'd2,
      ST_STOPPING = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] sh_width, sh_height, sh_hblank;
   logic [7:0]  sh_fps;
   logic        run, cfg_error, fv_d1, fv_fall;
   logic [15:0] frame_cnt;
   logic [15:0] rd_mux;
   logic        wr_valid, wr_shadow, commit_wr;
   logic        load_active, count_en, clr_cnt;
   logic        tmo_hit;

   assign fv_fall   = fv_d1 & ~fv_i;
   assign wr_shadow = cfg.cfg_wr_i && (cfg.cfg_addr_i[2] == 1'b0);
   assign commit_wr = cfg.cfg_wr_i && (cfg.cfg_addr_i == A_CTRL) && cfg.cfg_wdata_i[1];

   // Legality of a shadow write; the full 16-bit data word is judged.
   always_comb begin
      wr_valid = 1'b0;
      case (cfg.cfg_addr_i)
         A_WIDTH:  wr_valid = (cfg.cfg_wdata_i[2:0] == 3'd0) && (cfg.cfg_wdata_i >= 16'd16);
         A_HEIGHT: wr_valid = (cfg.cfg_wdata_i != 16'd0);
         A_HBLANK: wr_valid = (cfg.cfg_wdata_i != 16'd0);
         A_FPS:    wr_valid = (cfg.cfg_wdata_i == 16'd15) || (cfg.cfg_wdata_i == 16'd30) ||
                              (cfg.cfg_wdata_i == 16'd60);
         default:  wr_valid = 1'b0;
      endcase
   end

`ifdef TPG_SEQ_STOP_TIMEOUT_EN
   logic [31:0] tmo_cnt;

   // Counts cycles spent in STOPPING; restarts at zero on every entry.
   always_ff @(posedge clk) begin
      if (!reset_n || state != ST_STOPPING) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + 32'd1;
   end

   // fv_i still high means no FV fall is arriving this cycle.
   assign tmo_hit = (state == ST_STOPPING) && fv_i && (tmo_cnt == STOP_TIMEOUT_CYCLES - 32'd1);
`else
   logic unused_tmo;
   assign unused_tmo = ^STOP_TIMEOUT_CYCLES;
   assign tmo_hit    = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= ST_STOPPED;
      else          state <= state_nxt;
   end

   // Next state. STOPPING exits as soon as FV is low: either FV just fell
   // or no frame was in flight when the stop began.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_STOPPED:  if (run) state_nxt = ST_START;
         ST_START:    state_nxt = ST_RUNNING;
         ST_RUNNING:  if (!run) state_nxt = ST_STOPPING;
         ST_STOPPING: if (!fv_i || tmo_hit) state_nxt = ST_STOPPED;
         default:     state_nxt = ST_STOPPED;
      endcase
   end

   // State-decoded outputs and datapath controls
   always_comb begin
      gen_reset_n_o = (state != ST_STOPPED);
      running_o     = (state == ST_START) || (state == ST_RUNNING);
      load_active   = (state == ST_START) ||
                      ((state == ST_STOPPED) && cfg_pending_o) ||
                      ((state == ST_RUNNING) && cfg_pending_o && fv_fall);
      count_en      = ((state == ST_RUNNING) || (state == ST_STOPPING)) && fv_fall;
      clr_cnt       = (state == ST_START);
   end

   always_comb begin
      rd_mux = '0;
      case (cfg.cfg_addr_i)
         A_WIDTH:  rd_mux = sh_width;
         A_HEIGHT: rd_mux = sh_height;
         A_HBLANK: rd_mux = sh_hblank;
         A_FPS:    rd_mux = {8'd0, sh_fps};
         A_CTRL:   rd_mux = {15'd0, run};
         A_STAT:   rd_mux = {13'd0, cfg_error, cfg_pending_o, running_o};
         A_FCNT:   rd_mux = frame_cnt;
         default:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sh_width        <= DEFAULT_WIDTH;
         sh_height       <= DEFAULT_HEIGHT;
         sh_hblank       <= DEFAULT_HBLANK;
         sh_fps          <= DEFAULT_FPS;
         image_width_o   <= DEFAULT_WIDTH;
         image_height_o  <= DEFAULT_HEIGHT;
         line_blanking_o <= DEFAULT_HBLANK;
         img_fps_o       <= DEFAULT_FPS;
         run             <= 1'b0;
         cfg_error       <= 1'b0;
         cfg_pending_o   <= 1'b0;
         frame_done_o    <= 1'b0;
         frame_cnt       <= '0;
         fv_d1           <= 1'b0;
         cfg.cfg_rdata_o <= '0;
      end else begin
         fv_d1 <= fv_i;

         if (wr_shadow && wr_valid) begin
            case (cfg.cfg_addr_i)
               A_WIDTH:  sh_width  <= cfg.cfg_wdata_i;
               A_HEIGHT: sh_height <= cfg.cfg_wdata_i;
               A_HBLANK: sh_hblank <= cfg.cfg_wdata_i;
               default:  sh_fps    <= cfg.cfg_wdata_i[7:0];
            endcase
         end

         if (cfg.cfg_wr_i && cfg.cfg_addr_i == A_CTRL) run <= cfg.cfg_wdata_i[0];

         // A new error outranks a clear issued in the same cycle.
         if ((wr_shadow && !wr_valid) || tmo_hit)
            cfg_error <= 1'b1;
         else if (cfg.cfg_wr_i && cfg.cfg_addr_i == A_STAT && cfg.cfg_wdata_i[2])
            cfg_error <= 1'b0;

         // Active takes the shadow as it stood before any same-cycle write.
         if (load_active) begin
            image_width_o   <= sh_width;
            image_height_o  <= sh_height;
            line_blanking_o <= sh_hblank;
            img_fps_o       <= sh_fps;
         end

         // A commit landing on the apply cycle asks for another apply, so it
         // is kept rather than swallowed.
         if (commit_wr)        cfg_pending_o <= 1'b1;
         else if (load_active) cfg_pending_o <= 1'b0;

         frame_done_o <= count_en;
         if (clr_cnt)       frame_cnt <= '0;
         else if (count_en) frame_cnt <= frame_cnt + 16'd1;

         // Idle bus reads as zero so read data can be OR-combined upstream.
         cfg.cfg_rdata_o <= cfg.cfg_rd_i ? rd_mux : 16'd0;
      end
   end
endmodule

// File: tb/tb_tpg_frame_sequencer.sv
module tb_tpg_frame_sequencer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        fv = 1'b0;
   logic        gen_reset_n, running, pending, frame_done;
   logic [15:0] width, height, hblank;
   logic [7:0]  fps;

   tpg_frame_sequencer_if cfg ();

   tpg_frame_sequencer #(.STOP_TIMEOUT_CYCLES(50)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cfg             (cfg),
      .fv_i            (fv),
      .gen_reset_n_o   (gen_reset_n),
      .image_width_o   (width),
      .image_height_o  (height),
      .line_blanking_o (hblank),
      .img_fps_o       (fps),
      .running_o       (running),
      .cfg_pending_o   (pending),
      .frame_done_o    (frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: register-level view of what the host should see.
   localparam int DEF [4] = '{1920, 1080, 100, 30};
   int m_sh [4];
   int m_act [4];
   bit m_pend, m_err;
   int m_cnt;

   task automatic model_reset();
      m_sh = DEF; m_act = DEF; m_pend = 0; m_err = 0; m_cnt = 0;
   endtask

   function automatic bit legal(int a, int v);
      case (a)
         0:       return (v % 8 == 0) && (v >= 16);
         1, 2:    return v >= 1;
         default: return (v == 15) || (v == 30) || (v == 60);
      endcase
   endfunction

   function automatic int rand_val(int a);
      if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 300));
      case (a)
         0:       return int'(8 * $urandom_range(2, 400));
         1:       return int'($urandom_range(1, 2000));
         2:       return int'($urandom_range(1, 500));
         default: return ($urandom_range(0, 2) == 0) ? 15 : (($urandom_range(0, 1) == 1) ? 30 : 60);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_active(input string tag);
      chk({tag, "_w"}, width,  m_act[0]);
      chk({tag, "_h"}, height, m_act[1]);
      chk({tag, "_b"}, hblank, m_act[2]);
      chk({tag, "_f"}, fps,    m_act[3]);
   endtask

   task automatic wr(input int a, input int d);
      cfg.cfg_wr_i = 1'b1; cfg.cfg_addr_i = a[2:0]; cfg.cfg_wdata_i = d[15:0];
      tick();
      cfg.cfg_wr_i = 1'b0;
      if (a < 4) begin
         if (legal(a, d)) m_sh[a] = d; else m_err = 1;
      end else if (a == 4) begin
         if (d[1]) m_pend = 1;
      end else if (a == 5 && d[2]) m_err = 0;
   endtask

   task automatic rd(input int a, output logic [15:0] d);
      cfg.cfg_rd_i = 1'b1; cfg.cfg_addr_i = a[2:0];
      tick();
      cfg.cfg_rd_i = 1'b0;
      d = cfg.cfg_rdata_o;
   endtask

   task automatic chk_status(input string tag, input int run_exp);
      logic [15:0] d;
      rd(5, d);
      chk(tag, d, m_err * 4 + m_pend * 2 + run_exp);
   endtask

   // One frame while running: FV high for hi cycles, then the falling edge.
   task automatic frame(input int hi);
      fv = 1'b1;
      repeat (hi) begin tick(); chk("fd_idle", frame_done, 0); end
      fv = 1'b0;
      chk("act_hold", width, m_act[0]);
      tick();
      m_cnt++;
      if (m_pend) begin m_act = m_sh; m_pend = 0; end
      chk("fd_pulse", frame_done, 1);
      chk("pend_fall", pending, m_pend);
      chk_active("act_fall");
      tick();
      chk("fd_clear", frame_done, 0);
   endtask

   task automatic start_run();
      wr(4, 1);
      chk("gen_rst_e0", gen_reset_n, 0);
      tick();
      chk("gen_rst_e1", gen_reset_n, 1);
      chk("running_e1", running, 1);
      tick();
      m_act = m_sh; m_pend = 0; m_cnt = 0;
      chk_active("start");
   endtask

   initial begin
      logic [15:0] d;
      int n;
      cfg.cfg_wr_i = 1'b0; cfg.cfg_rd_i = 1'b0; cfg.cfg_addr_i = '0; cfg.cfg_wdata_i = '0;
      model_reset();
      repeat (3) tick();
      chk("rst_gen", gen_reset_n, 0);
      chk("rst_running", running, 0);
      chk("rst_pend", pending, 0);
      chk("rst_fd", frame_done, 0);
      chk("rst_rdata", cfg.cfg_rdata_o, 0);
      chk_active("rst_act");
      reset_n = 1'b1;
      for (int a = 0; a < 4; a++) begin rd(a, d); chk("rst_shadow", d, DEF[a]); end
      rd(6, d); chk("rst_fcnt", d, 0);
      chk_status("rst_status", 0);

      // Random shadow programming while stopped
      for (int i = 0; i < 16; i++) begin
         int a;
         a = int'($urandom_range(0, 3));
         wr(a, rand_val(a));
      end
      for (int a = 0; a < 4; a++) begin rd(a, d); chk("shadow_rb", d, m_sh[a]); end
      chk_status("status_rand", 0);
      chk_active("act_no_commit");

      // Illegal writes leave the shadow alone and set the sticky error
      wr(0, 100); wr(3, 25);
      rd(0, d); chk("bad_width", d, m_sh[0]);
      rd(3, d); chk("bad_fps", d, m_sh[3]);
      chk_status("err_set", 0);
      wr(5, 4);
      chk_status("err_clr", 0);

      // Commit while stopped applies one cycle later
      wr(0, 1280);
      wr(4, 2);
      chk("pend_stopped", pending, 1);
      chk_active("pre_commit");
      tick();
      m_act = m_sh; m_pend = 0;
      chk_active("stopped_commit");
      chk("pend_applied", pending, 0);

      // Start loads shadow (new width without commit)
      wr(0, 640);
      start_run();
      chk("pend_start", pending, 0);

      // Deferred commit lands on the FV fall
      wr(0, 320); wr(4, 3);
      chk("pend_run", pending, 1);
      frame(3);

      // Random running traffic
      for (int f = 0; f < 10; f++) begin
         n = int'($urandom_range(0, 3));
         for (int k = 0; k < n; k++) begin
            int a;
            a = int'($urandom_range(0, 3));
            wr(a, rand_val(a));
         end
         if ($urandom_range(0, 1) == 1) wr(4, 3);
         chk("pend_pre", pending, m_pend);
         frame(int'($urandom_range(1, 6)));
      end
      rd(6, d); chk("fcnt_run", d, m_cnt);

      // Shadow write in the apply cycle: active gets the older value
      wr(1, 720); wr(4, 3);
      fv = 1'b1; tick(); tick();
      fv = 1'b0; cfg.cfg_wr_i = 1'b1; cfg.cfg_addr_i = 3'd1; cfg.cfg_wdata_i = 16'd480;
      tick();
      cfg.cfg_wr_i = 1'b0;
      m_act = m_sh; m_pend = 0; m_cnt++; m_sh[1] = 480;
      chk("same_cyc_act", height, 720);
      chk("same_cyc_pend", pending, 0);
      rd(1, d); chk("same_cyc_sh", d, 480);

      // Read and write to the same address in one cycle returns old value
      cfg.cfg_wr_i = 1'b1; cfg.cfg_rd_i = 1'b1; cfg.cfg_addr_i = 3'd2; cfg.cfg_wdata_i = 16'd77;
      tick();
      cfg.cfg_wr_i = 1'b0; cfg.cfg_rd_i = 1'b0;
      chk("rw_old", cfg.cfg_rdata_o, m_sh[2]);
      m_sh[2] = 77;
      rd(2, d); chk("rw_new", d, 77);

      // Illegal writes while running
      wr(0, 100); wr(3, 25);
      chk_status("err_run", 1);
      wr(5, 4);
      chk_status("err_run_clr", 1);

      // Stop with FV high: waits for the fall, counts it
      fv = 1'b1; tick();
      wr(4, 0);
      tick();
      chk("stopping_run", running, 0);
      repeat (4) begin tick(); chk("stopping_hold", gen_reset_n, 1); end
      fv = 1'b0;
      chk("stopping_last", gen_reset_n, 1);
      tick();
      m_cnt++;
      chk("stop_fall_gen", gen_reset_n, 0);
      chk("stop_fall_fd", frame_done, 1);
      rd(6, d); chk("fcnt_stop", d, m_cnt);

      // Restart clears the count; stop with FV low completes in 2 cycles
      start_run();
      rd(6, d); chk("fcnt_clear", d, 0);
      frame(2);
      wr(4, 0);
      n = 0;
      while (gen_reset_n === 1'b1 && n < 2) begin tick(); n++; end
      chk("stop_fv_low", gen_reset_n, 0);

      // run rewritten during STOPPING: stop finishes, then restart
      start_run();
      fv = 1'b1; tick();
      wr(4, 0); tick();
      wr(4, 1);
      chk("rerun_hold", gen_reset_n, 1);
      chk("rerun_notrun", running, 0);
      fv = 1'b0; tick();
      chk("rerun_stopped", gen_reset_n, 0);
      tick();
      chk("rerun_start", running, 1);
      tick();
      m_cnt = 0; m_act = m_sh;
      rd(6, d); chk("rerun_fcnt", d, 0);

      // run=0 and commit together: stop, then the commit applies
      wr(1, 600); wr(4, 2);
      chk("stopcommit_pend", pending, 1);
      repeat (3) tick();
      m_act = m_sh; m_pend = 0;
      chk("stopcommit_gen", gen_reset_n, 0);
      chk("stopcommit_pend0", pending, 0);
      chk_active("stopcommit");

      // Reset mid-frame
      start_run();
      fv = 1'b1; tick();
      wr(0, 1024); wr(4, 3);
      reset_n = 1'b0; tick();
      model_reset();
      chk("midrst_gen", gen_reset_n, 0);
      chk("midrst_run", running, 0);
      chk("midrst_pend", pending, 0);
      chk_active("midrst");
      reset_n = 1'b1; fv = 1'b0;
      rd(0, d); chk("midrst_sh", d, 1920);
      chk_status("midrst_status", 0);

`ifdef TPG_SEQ_STOP_TIMEOUT_EN
      // FV stuck high: forced stop after STOP_TIMEOUT_CYCLES in STOPPING
      start_run();
      fv = 1'b1; tick();
      wr(4, 0); tick();
      n = 0;
      while (gen_reset_n === 1'b1 && n < 200) begin tick(); n++; end
      chk("tmo_cycles", n, 50);
      m_err = 1;
      chk_status("tmo_err", 0);
      fv = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
